// File: rtl/coarse_syn_pkg.sv
// Shared definitions for the coarse sync header transmit sequencer.
// - Default timing: clocks per code slot, clocks per chip, chips per code.
// - CODE_LAST: the code number that ends every header. The receiver anchors on it.
// - Width constants for the code number, chip index, slot counter and chip counter.
// - FSM state enum.
// - norm_count(): maps a requested code count to the count actually sent.
package coarse_syn_pkg;

  localparam int SLOT_CLKS_DEFAULT      = 2600;
  localparam int CHIP_CLKS_DEFAULT      = 40;
  localparam int CHIPS_PER_CODE_DEFAULT = 32;

  localparam int CODE_NUM_W = 4;
  localparam int CHIP_IDX_W = 5;
  localparam int SLOT_CNT_W = 12;
  localparam int CHIP_CNT_W = 6;

  localparam logic [CODE_NUM_W-1:0] CODE_LAST = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CODE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Valid requests are 1..4. A request of 0 or above 4 sends the full
  // four-code header.
  function automatic logic [2:0] norm_count(input logic [2:0] req);
    if (req == 3'd0 || req > 3'd4) return 3'd4;
    return req;
  endfunction

endpackage

// File: rtl/coarse_chip_timer.sv
// Slot and chip timing for one coarse sync code slot.
// A slot is CHIPS_PER_CODE chips of CHIP_CLKS clocks each, followed by a
// guard gap. The slot is SLOT_CLKS clocks long in total. Back-to-back slots
// follow with no gap for as long as run stays high.
//
// Ports:
//   logic_clk_in, logic_rst_in : clock, asynchronous active-high reset
//   clear        : forces every counter and output to zero for the next cycle
//   run          : the next cycle is a slot cycle
//                  (a first run cycle starts at slot offset 0)
//   chip_en      : registered, high during the chip portion of the slot
//   chip_strobe  : registered, one-cycle pulse on the first clock of each chip
//   chip_idx     : registered chip index; holds at the last chip through the guard
//   slot_last    : registered, high on the final clock of a slot
//   slot_cnt, chip_cnt : raw counters, exported for debug visibility
module coarse_chip_timer
  import coarse_syn_pkg::*;
#(
  parameter int SLOT_CLKS      = SLOT_CLKS_DEFAULT,
  parameter int CHIP_CLKS      = CHIP_CLKS_DEFAULT,
  parameter int CHIPS_PER_CODE = CHIPS_PER_CODE_DEFAULT
) (
  input  logic                  logic_clk_in,
  input  logic                  logic_rst_in,
  input  logic                  clear,
  input  logic                  run,
  output logic                  chip_en,
  output logic                  chip_strobe,
  output logic [CHIP_IDX_W-1:0] chip_idx,
  output logic                  slot_last,
  output logic [SLOT_CNT_W-1:0] slot_cnt,
  output logic [CHIP_CNT_W-1:0] chip_cnt
);

  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST_VAL = SLOT_CNT_W'(SLOT_CLKS - 1);
  localparam logic [SLOT_CNT_W-1:0] CHIP_SPAN_VAL = SLOT_CNT_W'(CHIPS_PER_CODE * CHIP_CLKS);
  localparam logic [CHIP_CNT_W-1:0] CHIP_LAST_VAL = CHIP_CNT_W'(CHIP_CLKS - 1);

  // active: the previous cycle was a slot cycle.
  // When it is low, the next slot cycle starts at offset 0.
  logic                  active;
  logic [SLOT_CNT_W-1:0] slot_nxt;
  logic [CHIP_CNT_W-1:0] chip_cnt_nxt;
  logic [CHIP_IDX_W-1:0] chip_idx_nxt;
  logic                  chip_en_nxt;

  // Next-cycle position. The outputs are registered from these values, so
  // they line up with the counters in the same cycle.
  always_comb begin
    slot_nxt     = '0;
    chip_cnt_nxt = '0;
    chip_idx_nxt = '0;
    if (active && slot_cnt != SLOT_LAST_VAL) slot_nxt = slot_cnt + 1'b1;
    chip_en_nxt = (slot_nxt < CHIP_SPAN_VAL);
    if (slot_nxt != '0) begin
      if (chip_en_nxt) begin
        if (chip_cnt == CHIP_LAST_VAL) begin
          chip_cnt_nxt = '0;
          chip_idx_nxt = chip_idx + 1'b1;
        end else begin
          chip_cnt_nxt = chip_cnt + 1'b1;
          chip_idx_nxt = chip_idx;
        end
      end else begin
        // Guard gap: freeze on the last chip.
        chip_cnt_nxt = chip_cnt;
        chip_idx_nxt = chip_idx;
      end
    end
  end

  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      active      <= 1'b0;
      slot_cnt    <= '0;
      chip_cnt    <= '0;
      chip_idx    <= '0;
      chip_en     <= 1'b0;
      chip_strobe <= 1'b0;
      slot_last   <= 1'b0;
    end else if (clear || !run) begin
      active      <= 1'b0;
      slot_cnt    <= '0;
      chip_cnt    <= '0;
      chip_idx    <= '0;
      chip_en     <= 1'b0;
      chip_strobe <= 1'b0;
      slot_last   <= 1'b0;
    end else begin
      active      <= 1'b1;
      slot_cnt    <= slot_nxt;
      chip_cnt    <= chip_cnt_nxt;
      chip_idx    <= chip_idx_nxt;
      chip_en     <= chip_en_nxt;
      chip_strobe <= chip_en_nxt && (chip_cnt_nxt == '0);
      slot_last   <= (slot_nxt == SLOT_LAST_VAL);
    end
  end

endmodule

// File: rtl/coarse_syn_tx_sequencer.sv
// Transmit-side coarse sync header sequencer.
// A start request sends N code slots (N = 1..4). The code numbers run from
// 5-N up to 4. A single-cycle sync_done pulse follows the last clock of
// code 4.
//
// Control handshake: tx_start_in is a level sampled only in IDLE. It is
// never queued. tx_abort_in is honoured only in CODE, where it takes
// priority over every slot transition. In IDLE, an abort that arrives
// together with a start suppresses that start. Every output is a flop,
// valid from the clock edge after the edge that samples the request.
//
// Ports:
//   logic_clk_in, logic_rst_in : 200 MHz clock, asynchronous active-high reset
//   tx_start_in, tx_abort_in   : header start / abort requests
//   code_count_in[2:0]         : number of codes to send (0 or >4 means 4)
//   code_num_out[3:0]          : current code number, 0 when not sending
//   chip_en_out, chip_strobe_out, chip_idx_out[4:0] : chip timing for the spreader
//   busy_out                   : high while sending codes
//   sync_done_out              : one-cycle pulse after the last clock of code 4
//   debug_signal[63:0]         : {32'0, state, latched N, code_num, slot_cnt, chip_cnt, chip_idx}
module coarse_syn_tx_sequencer
  import coarse_syn_pkg::*;
#(
  parameter int SLOT_CLKS      = SLOT_CLKS_DEFAULT,
  parameter int CHIP_CLKS      = CHIP_CLKS_DEFAULT,
  parameter int CHIPS_PER_CODE = CHIPS_PER_CODE_DEFAULT
) (
  input  logic                  logic_clk_in,
  input  logic                  logic_rst_in,
  input  logic                  tx_start_in,
  input  logic                  tx_abort_in,
  input  logic [2:0]            code_count_in,
  output logic [CODE_NUM_W-1:0] code_num_out,
  output logic                  chip_en_out,
  output logic                  chip_strobe_out,
  output logic [CHIP_IDX_W-1:0] chip_idx_out,
  output logic                  busy_out,
  output logic                  sync_done_out,
  output logic [63:0]           debug_signal
);

  if (CHIPS_PER_CODE * CHIP_CLKS > SLOT_CLKS) begin : g_bad_slot
    $fatal(1, "coarse_syn_tx_sequencer: chip portion exceeds slot length");
  end
  if (SLOT_CLKS > (1 << SLOT_CNT_W) || CHIP_CLKS > (1 << CHIP_CNT_W)) begin : g_bad_width
    $fatal(1, "coarse_syn_tx_sequencer: timing does not fit counter widths");
  end

  state_t                state, state_nxt;
  logic [2:0]            n_q, n_nxt;
  logic [CODE_NUM_W-1:0] code_num_nxt;
  logic                  timer_clear, timer_run, slot_last;
  logic [SLOT_CNT_W-1:0] slot_cnt;
  logic [CHIP_CNT_W-1:0] chip_cnt;

  always_comb begin
    state_nxt    = state;
    n_nxt        = n_q;
    code_num_nxt = code_num_out;
    timer_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start_in && !tx_abort_in) begin
          n_nxt        = norm_count(code_count_in);
          code_num_nxt = CODE_LAST + 4'd1 - {1'b0, n_nxt};
          state_nxt    = CODE;
        end
      end
      CODE: begin
        if (tx_abort_in) begin
          timer_clear = 1'b1;
          state_nxt   = IDLE;
        end else if (slot_last) begin
          if (code_num_out == CODE_LAST) state_nxt = DONE;
          else code_num_nxt = code_num_out + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    timer_run = (state_nxt == CODE);
  end

  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      state         <= IDLE;
      n_q           <= '0;
      code_num_out  <= '0;
      busy_out      <= 1'b0;
      sync_done_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      n_q           <= n_nxt;
      code_num_out  <= (state_nxt == CODE) ? code_num_nxt : '0;
      busy_out      <= (state_nxt == CODE);
      sync_done_out <= (state_nxt == DONE);
    end
  end

  coarse_chip_timer #(
    .SLOT_CLKS      (SLOT_CLKS),
    .CHIP_CLKS      (CHIP_CLKS),
    .CHIPS_PER_CODE (CHIPS_PER_CODE)
  ) u_chip_timer (
    .logic_clk_in (logic_clk_in),
    .logic_rst_in (logic_rst_in),
    .clear        (timer_clear),
    .run          (timer_run),
    .chip_en      (chip_en_out),
    .chip_strobe  (chip_strobe_out),
    .chip_idx     (chip_idx_out),
    .slot_last    (slot_last),
    .slot_cnt     (slot_cnt),
    .chip_cnt     (chip_cnt)
  );

  assign debug_signal = {32'd0, state, n_q, code_num_out, slot_cnt, chip_cnt, chip_idx_out};

endmodule

// File: doc/coarse_syn_tx_sequencer.md
Name: coarse_syn_tx_sequencer

Overview:
- Transmit-side generator for the coarse synchronisation header; it is the peer of the receive-side coarse sync statistics/decision logic.
- On a start request it emits a run of 1–4 coarse sync code slots, with code numbers ending at 4. Each slot is 32 chips of CHIP_CLKS clocks followed by a guard gap, for SLOT_CLKS clocks in total.
- The receiver anchors sync on code 4. So a one-cycle sync_done pulse marks the instant the receiver's delayed sync pulse (position 3) is expected.
- It sits between TX framing control and the chip spreader/modulator.

Parameters:
- SLOT_CLKS, 2600, clocks per code slot (chips plus guard).
- CHIP_CLKS, 40, clocks per chip.
- CHIPS_PER_CODE, 32, chips per code.
- Elaboration check: CHIPS_PER_CODE*CHIP_CLKS <= SLOT_CLKS, else fatal.

Ports:
- logic_clk_in, in, 1, 200 MHz logic clock.
- logic_rst_in, in, 1, asynchronous active-high reset.
- tx_start_in, in, 1, start request pulse; sampled only in IDLE.
- tx_abort_in, in, 1, abort the current header.
- code_count_in, in, 3, number of codes to send; 1..4 valid; 0 or >4 treated as 4. Latched at start.
- code_num_out, out, 4, current code number 1..4; 0 when not sending.
- chip_en_out, out, 1, high during the chip portion of a slot.
- chip_strobe_out, out, 1, one-cycle pulse at the first clock of each chip.
- chip_idx_out, out, 5, index 0..31 of the current chip.
- busy_out, out, 1, high while in CODE.
- sync_done_out, out, 1, one-cycle pulse after the last clock of code 4.
- debug_signal, out, 64, state, counters, latched count; unused bits 0.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs are 0 and all counters are 0.
- States: IDLE, CODE, DONE.
- IDLE:
  - tx_start_in=1 latches N (from code_count_in).
  - Next state is CODE with code_num = 5-N and slot_cnt=0.
  - Outputs are valid from the edge after the start sample (latency 1).
- CODE:
  - slot_cnt counts 0..SLOT_CLKS-1 (12-bit).
  - chip_en_out = (slot_cnt < CHIPS_PER_CODE*CHIP_CLKS).
  - chip_cnt (6-bit) counts 0..CHIP_CLKS-1 inside the chip portion.
  - chip_strobe_out = chip_en_out && chip_cnt==0.
  - chip_idx_out increments on each chip_cnt wrap. It holds at 31 through the guard and resets to 0 at slot start.
  - At slot_cnt==SLOT_CLKS-1:
    - code_num<4: code_num+1 and slot_cnt=0, with no gap between slots.
    - code_num==4: go to DONE.
- DONE: exactly one cycle, with sync_done_out=1, busy_out=0 and code_num_out=0; then IDLE.
- Header length: N*SLOT_CLKS CODE cycles. sync_done is asserted at start_edge+1+N*SLOT_CLKS.
- tx_start_in in CODE or DONE: ignored, with no queuing.
- tx_abort_in=1 in CODE: next cycle IDLE, all outputs 0, no sync_done. Abort wins over a simultaneous slot-end or final-slot transition.
- tx_abort_in in IDLE or DONE: no effect. Abort and start together in IDLE: start is ignored.
- Asynchronous reset mid-header: immediate return to IDLE and zero outputs. No sync_done is generated.
- All outputs are registered.

Decomposition:
- Package coarse_syn_pkg:
  - Defaults for SLOT_CLKS, CHIP_CLKS and CHIPS_PER_CODE.
  - CODE_LAST=4.
  - State enum {IDLE, CODE, DONE}.
  - Width constants: code num 4, chip idx 5, slot cnt 12.
- Sub-module coarse_chip_timer:
  - Owns slot_cnt, chip_cnt and chip_idx.
  - Inputs: clear, run. Outputs: chip_en, chip_strobe, chip_idx, slot_last.
  - The sequencer FSM instantiates it once.

Test Plan:
- code_count=4, start sampled at cycle 0:
  - code_num=1 for cycles 1..2600, 2 for 2601..5200, 3 for 5201..7800, 4 for 7801..10400.
  - sync_done=1 only at cycle 10401; busy=0 from 10401.
- code_count=1: code_num=4 for cycles 1..2600; sync_done at 2601. code_count=0 and 7 behave exactly as 4.
- Chip timing within one slot:
  - chip_en high for slot cycles 0..1279.
  - 32 strobes at slot offsets 0,40,...,1240; chip_idx 0..31.
  - chip_en low for offsets 1280..2599.
- Abort:
  - code_count=4, tx_abort at cycle 3000 (code 2): all outputs 0 from cycle 3001, no sync_done.
  - Repeat with abort on cycle 10400: no sync_done.
- Start at cycle 500 while busy is ignored: timeline identical to the single-start case. A new start in cycle 10402 is accepted.
- Reset asserted asynchronously mid-code 3: outputs 0 without waiting for a clock edge. After release, IDLE waits for tx_start.
